gcd_operand_parser: RTL and testbench

//  Upstream feeder for the GCD core. It consumes bytes from the UART receiver and parses two

---
 rtl/gcd_operand_parser.sv | 143 ++++++++++++++
 tb/tb_gcd_operand_parser.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_operand_parser.sv
// Purpose : parse "<A><sep><B><eol>" ASCII-decimal operand pairs from UART RX bytes for the GCD core.
// Latency : op_valid / err are registered and appear the cycle after the terminating byte is sampled.
// Backpressure: none on rx (one byte per cycle accepted); while a pair is held, rx bytes are dropped until op_ack.
//
// Ports:
//   clk, rst          clock and synchronous active-low reset
//   rx_data/rx_valid  byte stream from UART RX (rx_valid is a 1-cycle strobe)
//   d1/d2             parsed operands A and B, frozen while op_valid=1
//   op_valid/op_ack   pair handshake; op_valid stays high until op_ack is sampled
//   err               1-cycle pulse on malformed, zero or overflowing operand
module gcd_operand_parser #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic              op_valid,
  input  logic              op_ack,
  output logic              err
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ACC_W = DATA_W + 4;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [2:0]        ndig;
  logic              ovf;

  // Byte classification
  logic is_digit, is_sep, is_eol;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C);
  assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);

  // acc*10 + digit; 4 extra bits hold the worst case (2^DATA_W-1)*10+9.
  // For bytes 0x30-0x39 the low nibble is exactly the digit value.
  logic [ACC_W-1:0] nxt;
  logic             nxt_ovf;
  assign nxt     = ({4'b0000, acc} * ACC_W'(10)) + ACC_W'(rx_data[3:0]);
  assign nxt_ovf = nxt > {4'b0000, {DATA_W{1'b1}}};

  logic op_ok;
  assign op_ok = (ndig != 3'd0) && !ovf && (acc != '0);

  // Action strobes decoded from state and the current byte
  logic act_accum, act_load_d1, act_load_d2, act_err, act_release;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= GET_A;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (act_err)                       state_nxt = GET_A;
    else if (act_load_d1)              state_nxt = GET_B;
    else if (act_load_d2)              state_nxt = HOLD;
    else if (act_release)              state_nxt = GET_A;
  end

  // Output / action decode
  always_comb begin
    act_accum   = 1'b0;
    act_load_d1 = 1'b0;
    act_load_d2 = 1'b0;
    act_err     = 1'b0;
    act_release = 1'b0;
    unique case (state)
      GET_A: begin
        if (rx_valid) begin
          if (is_digit)                   act_accum   = 1'b1;
          else if (is_sep || is_eol) begin
            // Separators and blank lines before any digit are skipped
            if (ndig == 3'd0)             ;
            else if (is_sep && op_ok)     act_load_d1 = 1'b1;
            else                          act_err     = 1'b1;
          end
          else                            act_err     = 1'b1;
        end
      end
      GET_B: begin
        if (rx_valid) begin
          if (is_digit)                       act_accum   = 1'b1;
          else if (is_sep && ndig == 3'd0)    ;
          else if (is_eol && op_ok)           act_load_d2 = 1'b1;
          else                                act_err     = 1'b1;
        end
      end
      HOLD: begin
        // Bytes are dropped here, including one that coincides with op_ack
        if (op_ack) act_release = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      ndig     <= 3'd0;
      ovf      <= 1'b0;
      d1       <= '0;
      d2       <= '0;
      op_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= act_err;

      if (act_accum) begin
        // On overflow acc keeps its last in-range value; ovf alone poisons the operand
        if (nxt_ovf) ovf <= 1'b1;
        else         acc <= nxt[DATA_W-1:0];
        if (ndig != 3'd7) ndig <= ndig + 3'd1;
      end

      if (act_load_d1 || act_load_d2 || act_err) begin
        acc  <= '0;
        ndig <= 3'd0;
        ovf  <= 1'b0;
      end

      if (act_load_d1) d1 <= acc;
      if (act_load_d2) begin
        d2       <= acc;
        op_valid <= 1'b1;
      end
      if (act_release) op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_operand_parser.sv
module tb_gcd_operand_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        op_ack = 1'b0;
  logic [15:0] d1, d2;
  logic        op_valid, err;

  gcd_operand_parser #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .d1(d1), .d2(d2), .op_valid(op_valid), .op_ack(op_ack), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  // Reference model: phase 0 = reading A, 1 = reading B, 2 = pair held
  int          m_phase;
  bit          m_have;
  longint      m_val;
  bit          m_big;
  logic [15:0] m_d1, m_d2;
  bit          m_valid, m_err;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_have = 0; m_val = 0; m_big = 0;
  endtask

  task automatic model_step(input bit r, input logic [7:0] b, input bit v, input bit a);
    bit ok;
    m_err = 0;
    if (!r) begin
      m_phase = 0; model_clear(); m_d1 = 0; m_d2 = 0; m_valid = 0;
      return;
    end
    if (m_phase == 2) begin
      if (a) begin m_valid = 0; m_phase = 0; end
      return;
    end
    if (!v) return;
    ok = m_have && !m_big && (m_val != 0);
    if (b >= "0" && b <= "9") begin
      m_have = 1;
      m_val  = m_val * 10 + longint'(b - 8'h30);
      if (m_val > 65535) begin m_big = 1; m_val = 65536; end
    end else if (b == " " || b == ",") begin
      if (!m_have) ;
      else if (m_phase == 0 && ok) begin
        m_d1 = 16'(m_val); m_phase = 1; model_clear();
      end else begin
        m_err = 1; m_phase = 0; model_clear();
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (m_phase == 0 && !m_have) ;
      else if (m_phase == 1 && ok) begin
        m_d2 = 16'(m_val); m_valid = 1; m_phase = 2; model_clear();
      end else begin
        m_err = 1; m_phase = 0; model_clear();
      end
    end else begin
      m_err = 1; m_phase = 0; model_clear();
    end
  endtask

  // One clock: drive inputs, let the DUT and model take the edge, then compare
  task automatic cycle(input logic [7:0] b, input bit v, input bit a, input bit r);
    rx_data = b; rx_valid = v; op_ack = a; rst = r;
    @(posedge clk);
    model_step(r, b, v, a);
    #1;
    chk("d1", d1, m_d1);
    chk("d2", d2, m_d2);
    chk("op_valid", op_valid, m_valid);
    chk("err", err, m_err);
    if (err) err_seen++;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(s[i], 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    string       s;
    logic [15:0] d1;
    logic [15:0] d2;
    bit          vld;
    int          errs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{s: "12 18\r",        d1: 16'd12,    d2: 16'd18,    vld: 1, errs: 0};
    vecs[1] = '{s: "65535,65535\n",  d1: 16'd65535, d2: 16'd65535, vld: 1, errs: 0};
    vecs[2] = '{s: "65536 5\r",      d1: 16'd65535, d2: 16'd65535, vld: 0, errs: 2};
    vecs[3] = '{s: "0 7\r",          d1: 16'd65535, d2: 16'd65535, vld: 0, errs: 2};
    vecs[4] = '{s: "7 00\r",         d1: 16'd7,     d2: 16'd65535, vld: 0, errs: 1};
    vecs[5] = '{s: "  007 21\r",     d1: 16'd7,     d2: 16'd21,    vld: 1, errs: 0};
    vecs[6] = '{s: "4x",             d1: 16'd7,     d2: 16'd21,    vld: 0, errs: 1};
    vecs[7] = '{s: "8 6\r",          d1: 16'd8,     d2: 16'd6,     vld: 1, errs: 0};

    // Reset state
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_d1", d1, 0);
    chk("reset_d2", d2, 0);
    chk("reset_op_valid", op_valid, 0);
    chk("reset_err", err, 0);
    idle(2);

    // Table-driven directed vectors
    for (int k = 0; k < 8; k++) begin
      err_seen = 0;
      send_str(vecs[k].s);
      idle(5);
      chk($sformatf("vec%0d_d1", k), d1, vecs[k].d1);
      chk($sformatf("vec%0d_d2", k), d2, vecs[k].d2);
      chk($sformatf("vec%0d_op_valid", k), op_valid, vecs[k].vld);
      chk($sformatf("vec%0d_err_pulses", k), err_seen, vecs[k].errs);
      if (vecs[k].vld) begin
        cycle(8'h00, 1'b0, 1'b1, 1'b1);
        chk($sformatf("vec%0d_ack_drop", k), op_valid, 0);
        idle(1);
      end
    end

    // HOLD ignores traffic; byte coinciding with op_ack is dropped
    send_str("9 3\r");
    send_str("99 1\r");
    chk("hold_d1", d1, 9);
    chk("hold_d2", d2, 3);
    chk("hold_valid", op_valid, 1);
    cycle("5", 1'b1, 1'b1, 1'b1);
    chk("ack_with_byte_valid", op_valid, 0);
    send_str("2 4\r");
    chk("after_drop_d1", d1, 2);
    chk("after_drop_d2", d2, 4);
    cycle(8'h00, 1'b0, 1'b1, 1'b1);

    // Reset mid-parse discards partial input
    send_str("123 4");
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst_d1", d1, 0);
    chk("midrst_d2", d2, 0);
    chk("midrst_valid", op_valid, 0);
    send_str("5 10\r");
    chk("post_rst_d1", d1, 5);
    chk("post_rst_d2", d2, 10);
    chk("post_rst_valid", op_valid, 1);
    cycle(8'h00, 1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int     r;
      logic [7:0] b;
      bit     v, a, rs;
      r = $urandom_range(0, 99);
      if      (r < 60) b = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 72) b = " ";
      else if (r < 76) b = ",";
      else if (r < 86) b = 8'h0D;
      else if (r < 92) b = 8'h0A;
      else if (r < 96) b = "x";
      else             b = 8'($urandom_range(0, 255));
      v  = ($urandom_range(0, 3) != 0);
      a  = op_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      rs = ($urandom_range(0, 499) != 0);
      cycle(b, v, a, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
